leb128_decoder: RTL and testbench

LEB128_DECODER -- requirements
Module: leb128_decoder

---
 rtl/leb128_decoder_if.sv | 32 +++
 rtl/leb128_decoder.sv | 163 ++++++++++++++++
 tb/tb_leb128_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/leb128_decoder_if.sv
// ----------------------------------------------------------------------------
// leb128_decoder_if: start/byte-stream/result bundle for the LEB128 decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface leb128_decoder_if;
  logic        start;
  logic        is_signed;
  logic        is_64;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_valid;
  logic        busy;
  logic        error;
  logic [1:0]  err_code;

  modport master (
    output start, is_signed, is_64, in_data, in_valid,
    input  in_ready, out_value, out_len, out_valid, busy, error, err_code
  );

  modport slave (
    input  start, is_signed, is_64, in_data, in_valid,
    output in_ready, out_value, out_len, out_valid, busy, error, err_code
  );
endinterface

`default_nettype wire

// File: rtl/leb128_decoder.sv
// ----------------------------------------------------------------------------
// leb128_decoder: byte-serial ULEB128/SLEB128 decoder for 32/64-bit immediates
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module leb128_decoder (
  input  wire logic        clk,
  input  wire logic        reset,
  leb128_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        signed_q, signed_d;
  logic        wide_q, wide_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  count_q, count_d;
  logic [63:0] out_value_q, out_value_d;
  logic [3:0]  out_len_q, out_len_d;
  logic        out_valid_q, out_valid_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [6:0]  shift_amt;
  logic [6:0]  ext_amt;
  logic [6:0]  width_bits;
  logic [3:0]  count_inc;
  logic [3:0]  max_len;
  logic        last_byte;
  logic        pad_ok;
  logic [63:0] acc_merged;
  logic [63:0] result;

  always_comb begin
    shift_amt  = {count_q, 3'b000} - {3'b000, count_q};
    ext_amt    = shift_amt + 7'd7;
    width_bits = wide_q ? 7'd64 : 7'd32;
    count_inc  = count_q + 4'd1;
    max_len    = wide_q ? 4'd10 : 4'd5;
    last_byte  = (count_inc == max_len);
    acc_merged = acc_q | ({57'd0, bus.in_data[6:0]} << shift_amt);

    // The final byte of a maximal-length encoding carries bits past the
    // target width; they must be zero (unsigned) or copies of the sign.
    if (wide_q) begin
      pad_ok = signed_q ? ((bus.in_data[6:0] == 7'h00) || (bus.in_data[6:0] == 7'h7F))
                        : (bus.in_data[6:1] == 6'd0);
    end else begin
      pad_ok = signed_q ? (bus.in_data[6:4] == {3{bus.in_data[3]}})
                        : (bus.in_data[6:4] == 3'd0);
    end

    result = acc_merged;
    if (signed_q && bus.in_data[6] && (ext_amt < width_bits)) begin
      result = result | (~64'd0 << ext_amt);
    end
    if (!wide_q) begin
      result[63:32] = 32'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    signed_d    = signed_q;
    wide_d      = wide_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_value_d = out_value_q;
    out_len_d   = out_len_q;
    out_valid_d = 1'b0;
    error_d     = error_q;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          state_d    = S_ACCUM;
          signed_d   = bus.is_signed;
          wide_d     = bus.is_64;
          acc_d      = 64'd0;
          count_d    = 4'd0;
          error_d    = 1'b0;
          err_code_d = 2'd0;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          if (bus.in_data[7]) begin
            if (last_byte) begin
              state_d    = S_ERROR;
              error_d    = 1'b1;
              err_code_d = 2'd1;
            end else begin
              acc_d   = acc_merged;
              count_d = count_inc;
            end
          end else if (last_byte && !pad_ok) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = 2'd2;
          end else begin
            state_d     = S_DONE;
            acc_d       = acc_merged;
            count_d     = count_inc;
            out_value_d = result;
            out_len_d   = count_inc;
            out_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      signed_q    <= 1'b0;
      wide_q      <= 1'b0;
      acc_q       <= 64'd0;
      count_q     <= 4'd0;
      out_value_q <= 64'd0;
      out_len_q   <= 4'd0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      signed_q    <= signed_d;
      wide_q      <= wide_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_value_q <= out_value_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
  assign bus.out_value = out_value_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_valid = out_valid_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_leb128_decoder.sv
// ----------------------------------------------------------------------------
// tb_leb128_decoder: directed self-checking bench for leb128_decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_leb128_decoder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  leb128_decoder_if bus ();

  leb128_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  {63'd0, bus.in_ready},  64'd0);
    chk({tag, ".out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, ".busy"},      {63'd0, bus.busy},      64'd0);
    chk({tag, ".error"},     {63'd0, bus.error},     64'd0);
    chk({tag, ".err_code"},  {62'd0, bus.err_code},  64'd0);
    chk({tag, ".out_value"}, bus.out_value,          64'd0);
    chk({tag, ".out_len"},   {60'd0, bus.out_len},   64'd0);
  endtask

  task automatic do_start(input logic s, input logic w);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.is_64     = w;
    tick();
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.is_64     = 1'b0;
  endtask

  // gap idle cycles precede the byte; poke drives a stray start during them
  task automatic send(input logic [7:0] b, input int gap, input logic poke);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid  = 1'b0;
      bus.start     = poke;
      bus.is_signed = poke;
      bus.is_64     = poke;
      tick();
    end
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.is_64     = 1'b0;
    bus.in_data   = b;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [63:0] exp_v, input logic [3:0] exp_l);
    chk({tag, ".out_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, ".out_value"}, bus.out_value,          exp_v);
    chk({tag, ".out_len"},   {60'd0, bus.out_len},   {60'd0, exp_l});
    chk({tag, ".busy"},      {63'd0, bus.busy},      64'd1);
    chk({tag, ".error"},     {63'd0, bus.error},     64'd0);
    tick();
    chk({tag, ".valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, ".value_hold"}, bus.out_value,          exp_v);
    chk({tag, ".idle_busy"},  {63'd0, bus.busy},      64'd0);
  endtask

  task automatic run_seq(input string tag, input logic s, input logic w, input int n,
                         input logic [79:0] bytes, input logic [63:0] exp_v,
                         input logic [3:0] exp_l);
    do_start(s, w);
    for (int i = 0; i < n; i++) send(bytes[i*8 +: 8], 0, 1'b0);
    check_done(tag, exp_v, exp_l);
  endtask

  task automatic run_err(input string tag, input logic s, input logic w, input int n,
                         input logic [79:0] bytes, input logic [1:0] exp_code);
    do_start(s, w);
    for (int i = 0; i < n; i++) send(bytes[i*8 +: 8], 0, 1'b0);
    chk({tag, ".error"},     {63'd0, bus.error},     64'd1);
    chk({tag, ".err_code"},  {62'd0, bus.err_code},  {62'd0, exp_code});
    chk({tag, ".out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, ".busy"},      {63'd0, bus.busy},      64'd0);
    chk({tag, ".in_ready"},  {63'd0, bus.in_ready},  64'd0);
    tick();
    chk({tag, ".err_hold"},  {63'd0, bus.error},     64'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.is_64     = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // reset wins over a simultaneous start
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("reset_vs_start.in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("reset_vs_start.busy",     {63'd0, bus.busy},     64'd0);
    reset = 1'b0;
    tick();

    run_seq("u32_03", 1'b0, 1'b0, 1, 80'h03, 64'd3, 4'd1);
    run_seq("u32_e58e26", 1'b0, 1'b0, 3, 80'h268EE5, 64'h98765, 4'd3);
    run_seq("s32_7f", 1'b1, 1'b0, 1, 80'h7F, 64'h00000000FFFFFFFF, 4'd1);
    run_seq("s64_807f", 1'b1, 1'b1, 2, 80'h7F80, 64'hFFFFFFFFFFFFFF80, 4'd2);

    // byte offered alongside start must not be consumed
    bus.in_data  = 8'h85;
    bus.in_valid = 1'b1;
    do_start(1'b0, 1'b0);
    send(8'h03, 0, 1'b0);
    check_done("start_byte_ignored", 64'd3, 4'd1);

    run_err("u32_too_long", 1'b0, 1'b0, 5, 80'h8080808080, 2'd1);
    run_err("u32_bad_pad",  1'b0, 1'b0, 5, 80'h1FFFFFFFFF, 2'd2);
    run_seq("u32_max", 1'b0, 1'b0, 5, 80'h0FFFFFFFFF, 64'h00000000FFFFFFFF, 4'd5);
    run_seq("s32_5th_ok", 1'b1, 1'b0, 5, 80'h7880808080, 64'h0000000080000000, 4'd5);
    run_err("s32_bad_pad", 1'b1, 1'b0, 5, 80'h7080808080, 2'd2);
    run_seq("s64_minus1", 1'b1, 1'b1, 10, 80'h7FFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'd10);
    run_seq("u64_max", 1'b0, 1'b1, 10, 80'h01FFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'd10);
    run_err("u64_bad_pad", 1'b0, 1'b1, 10, 80'h02FFFFFFFFFFFFFFFFFF, 2'd2);
    run_err("u64_too_long", 1'b0, 1'b1, 10, 80'h80808080808080808080, 2'd1);

    // stalls with stray starts in the gaps
    do_start(1'b0, 1'b0);
    chk("stall.error_cleared", {63'd0, bus.error}, 64'd0);
    send(8'hE5, 0, 1'b1);
    send(8'h8E, 3, 1'b1);
    send(8'h26, 2, 1'b1);
    check_done("stall", 64'h98765, 4'd3);

    // reset mid-decode
    do_start(1'b0, 1'b0);
    send(8'hE5, 1, 1'b0);
    send(8'h8E, 0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("mid_reset");
    run_seq("after_reset", 1'b0, 1'b0, 1, 80'h03, 64'd3, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
